// File: rtl/fifo_rr_reader.sv
// fifo_rr_reader: round-robin drain of a FIFO bank into one downstream FIFO,
// with threshold-load INIT state and a sticky ERROR state.
module fifo_rr_reader #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 6,
  parameter int TH_WIDTH   = 5
) (
  input  logic                            clk,
  input  logic                            RESET_L,
  input  logic                            init,
  input  logic [TH_WIDTH-1:0]             al_empty_in,
  input  logic [TH_WIDTH-1:0]             al_full_in,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS-1:0]            fifo_valid,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_FIFOS-1:0]            err_fifo,
  input  logic                            dest_pause,
  output logic [NUM_FIFOS-1:0]            fifo_rd,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            push,
  output logic [TH_WIDTH-1:0]             al_empty_th,
  output logic [TH_WIDTH-1:0]             al_full_th,
  output logic [2:0]                      state,
  output logic                            idle,
  output logic                            error_out
);
  localparam int PW = $clog2(NUM_FIFOS);
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;
  state_t                r_state;
  logic [PW-1:0]         r_ptr;
  logic [NUM_FIFOS-1:0]  r_rd;
  logic [NUM_FIFOS-1:0]  r_rd_q;
  logic [1:0]            r_inflight;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_push;
  logic [TH_WIDTH-1:0]   r_ae_th;
  logic [TH_WIDTH-1:0]   r_af_th;
  logic [NUM_FIFOS-1:0]  w_elig;
  logic [NUM_FIFOS-1:0]  w_match;
  logic [PW-1:0]         w_grant;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_vdata;
  int                    w_cand;
  // The FIFO granted last cycle is skipped: its empty flag has not caught up yet.
  always_comb begin
    w_elig  = ~fifo_empty & ~r_rd;
    w_grant = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = NUM_FIFOS; k >= 1; k--) begin
      w_cand = (int'(r_ptr) + k) % NUM_FIFOS;
      if (w_elig[w_cand[PW-1:0]]) begin
        w_grant = w_cand[PW-1:0];
        w_found = 1'b1;
      end
    end
  end
  // Only a valid answering last cycle's read is accepted; lowest index wins.
  always_comb begin
    w_match = fifo_valid & r_rd_q;
    w_vdata = '0;
    for (int i = NUM_FIFOS - 1; i >= 0; i--)
      if (w_match[i]) w_vdata = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state    <= S_RESET;
      r_ptr      <= PW'(NUM_FIFOS - 1);
      r_rd       <= '0;
      r_rd_q     <= '0;
      r_inflight <= '0;
      r_data     <= '0;
      r_push     <= 1'b0;
      r_ae_th    <= '0;
      r_af_th    <= '0;
    end else begin
      r_rd       <= '0;
      r_push     <= 1'b0;
      r_rd_q     <= r_rd;
      r_inflight <= r_inflight + {1'b0, |r_rd} - {1'b0, |r_rd_q};
      if (|err_fifo && (r_state == S_INIT || r_state == S_IDLE || r_state == S_ACTIVE))
        r_state <= S_ERROR;
      else
        case (r_state)
          S_RESET: r_state <= S_INIT;
          S_INIT: begin
            if (init) begin
              r_ae_th <= al_empty_in;
              r_af_th <= al_full_in;
            end else r_state <= S_IDLE;
          end
          S_IDLE: r_state <= init ? S_INIT : (~&fifo_empty ? S_ACTIVE : S_IDLE);
          S_ACTIVE: begin
            if (w_found && !dest_pause) begin
              r_rd  <= NUM_FIFOS'(1) << w_grant;
              r_ptr <= w_grant;
            end
            if (|w_match) begin
              r_data <= w_vdata;
              r_push <= 1'b1;
            end
            if (&fifo_empty && r_rd == '0 && r_inflight == 2'd0) r_state <= S_IDLE;
          end
          default: r_state <= r_state;
        endcase
    end
  end
  assign fifo_rd     = r_rd;
  assign data_out    = r_data;
  assign push        = r_push;
  assign al_empty_th = r_ae_th;
  assign al_full_th  = r_af_th;
  assign state       = r_state;
  assign idle        = (r_state == S_IDLE);
  assign error_out   = (r_state == S_ERROR);
endmodule

// File: doc/fifo_rr_reader.md
Name: fifo_rr_reader

Overview:
Drain side of the per-lane FIFO bank. Reads NUM_FIFOS FIFOs round-robin and forwards each 6-bit word to a single downstream FIFO through a push strobe. Stops issuing reads while the downstream FIFO asserts pause. Owns a small control FSM: init loads the almost-empty/almost-full thresholds that are distributed to the FIFO bank, and a sticky error state catches FIFO faults.

Parameters:
NUM_FIFOS, 4, number of upstream FIFOs served (2..8)
DATA_WIDTH, 6, word width
TH_WIDTH, 5, threshold width

Ports:
clk  input  1  clock, all state on rising edge
RESET_L  input  1  reset, asynchronous, active-low
init  input  1  threshold load request
al_empty_in  input  TH_WIDTH  almost-empty threshold to load
al_full_in  input  TH_WIDTH  almost-full threshold to load
fifo_empty  input  NUM_FIFOS  empty flag per upstream FIFO
fifo_valid  input  NUM_FIFOS  read-data valid per upstream FIFO
fifo_data  input  NUM_FIFOS*DATA_WIDTH  read data, FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH]
err_fifo  input  NUM_FIFOS  error flag per upstream FIFO
dest_pause  input  1  downstream FIFO pause
fifo_rd  output  NUM_FIFOS  registered one-hot read strobe
data_out  output  DATA_WIDTH  registered forwarded word
push  output  1  registered downstream write strobe
al_empty_th  output  TH_WIDTH  registered threshold to the FIFO bank
al_full_th  output  TH_WIDTH  registered threshold to the FIFO bank
state  output  3  FSM state encoding
idle  output  1  high in IDLE
error_out  output  1  high in ERROR

Behaviour:
- Reset (RESET_L=0, async): state=RESET(3'd0), fifo_rd=0, push=0, data_out=0, al_empty_th=0, al_full_th=0, idle=0, error_out=0, rr pointer=NUM_FIFOS-1, in-flight count=0. On the first edge with RESET_L=1: RESET->INIT.
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- INIT: each cycle with init=1, al_empty_th<=al_empty_in and al_full_th<=al_full_in. The first edge with init=0 moves to IDLE. No reads are issued in INIT.
- IDLE: idle=1. If any fifo_empty bit is 0, go to ACTIVE. If init=1, go to INIT; this takes priority over the move to ACTIVE.
- ACTIVE: at most one read is issued per cycle. Eligible FIFO = fifo_empty[i]=0 AND i not granted in the previous cycle; the 1-cycle exclusion avoids underflow, because the FIFO's empty flag lags its counter. Grant = first eligible index after the rr pointer, searching modulo NUM_FIFOS. fifo_rd[grant]<=1 and the pointer updates to grant. No grant if dest_pause=1 or no FIFO is eligible; fifo_rd<=0.
- Single nonempty FIFO: it is read every other cycle.
- Read pipeline: fifo_rd is asserted in cycle N. The FIFO returns fifo_valid[i]=1 with its data in cycle N+1. Then data_out<=fifo_data[i] and push<=1, visible in cycle N+2. Read-to-push latency is 2 cycles.
- A valid with no matching outstanding read is ignored.
- If several valid bits are set, the lowest index is taken.
- dest_pause only blocks new reads. Words already in flight (at most 2) are still pushed; the downstream almost-full threshold must absorb them.
- ACTIVE->IDLE when all fifo_empty=1, no fifo_rd is pending and the in-flight count=0. init=1 in ACTIVE is ignored.
- ERROR: entered from INIT, IDLE or ACTIVE on the edge where any err_fifo bit=1. It takes priority over every other transition. Outputs: fifo_rd<=0, push<=0, error_out=1, data_out holds its value. ERROR is left only by reset.
- Reset mid-operation: all in-flight words are dropped, with no push after reset deasserts.

Test Plan:
- Reset, then init=1 with al_empty_in=2 and al_full_in=6 for 2 cycles, then init=0 -> al_empty_th=2, al_full_th=6, state INIT->IDLE, idle=1, fifo_rd=0 throughout.
- FIFOs 0..3 each hold 1 word (0x01,0x02,0x03,0x04), dest_pause=0 -> fifo_rd sequence 0001,0010,0100,1000 on consecutive cycles. push on 4 consecutive cycles starting 2 cycles after the first rd, data_out 0x01..0x04. Then return to IDLE.
- Only FIFO 2 is nonempty, holding 3 words -> fifo_rd=0100 on alternating cycles, 3 pushes, never back-to-back rd to the same FIFO.
- dest_pause=1 raised one cycle after the first grant, all 4 FIFOs full -> no further fifo_rd, exactly 1 push completes. Drop dest_pause -> round-robin resumes at index 1.
- err_fifo[3]=1 in ACTIVE -> next edge state=ERROR, error_out=1, fifo_rd=0, push=0. It stays there with all inputs cleared until RESET_L=0.
- RESET_L pulled low with 2 words in flight -> outputs zero immediately (asynchronous), no push after release, state=RESET then INIT.
